multicycle_ctrl: RTL and testbench

- Multicycle sequencer for the ARM calculator datapath (Fetch/Decode/Execution/Mem/WriteBack stages).
- Decodes the current instruction, evaluates its condition against an internal NZCV register, and drives the datapath control inputs one state at a time.
- Write strobes (RegWrite, MemWrite, PCWrite, PCSrc) pulse for exactly one cycle per instruction.
- Sits between the instruction word and ALUFlags coming out of the datapath and the control pins going back into it.

---
 rtl/multicycle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the ARM calculator datapath.
// Holds the latched instruction fields and the NZCV register; all control outputs are Moore.
module multicycle_ctrl #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RUN,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ALUSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  Flags,
    output logic [2:0]  State,
    output logic        InstrDone,
    output logic        Illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [11:0] ir;
    logic [3:0]  flags;
    logic        illegal;

    // Only IR[31:20] drives control; the operand fields belong to the datapath.
    logic        unused_instr;
    assign unused_instr = ^Instr[19:0];

    logic [3:0] cond;
    logic [1:0] op;
    logic       imm;
    logic [3:0] cmd;
    logic       sbit;
    logic       is_dp;
    logic       is_mem;
    logic       is_br;
    logic       is_cmp;
    logic       cmd_ok;
    logic       bad;
    logic       cond_pass;
    logic [1:0] alu_op;

    assign cond   = ir[11:8];
    assign op     = ir[7:6];
    assign imm    = ir[5];
    assign cmd    = ir[4:1];
    assign sbit   = ir[0];
    assign is_dp  = (op == 2'b00);
    assign is_mem = (op == 2'b01);
    assign is_br  = (op == 2'b10);
    assign is_cmp = (cmd == 4'b1010);
    assign bad    = (op == 2'b11) || (is_dp && !cmd_ok);

    always_comb begin
        alu_op = 2'b00;
        cmd_ok = 1'b1;
        case (cmd)
            4'b0100: alu_op = 2'b00;
            4'b0010: alu_op = 2'b01;
            4'b0000: alu_op = 2'b10;
            4'b1100: alu_op = 2'b11;
            4'b1010: alu_op = 2'b01;
            default: cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flags[2];
            4'b0001: cond_pass = !flags[2];
            4'b0010: cond_pass = flags[1];
            4'b0011: cond_pass = !flags[1];
            4'b0100: cond_pass = flags[3];
            4'b0101: cond_pass = !flags[3];
            4'b0110: cond_pass = flags[0];
            4'b0111: cond_pass = !flags[0];
            4'b1000: cond_pass = flags[1] && !flags[2];
            4'b1001: cond_pass = !flags[1] || flags[2];
            4'b1010: cond_pass = (flags[3] == flags[0]);
            4'b1011: cond_pass = (flags[3] != flags[0]);
            4'b1100: cond_pass = !flags[2] && (flags[3] == flags[0]);
            4'b1101: cond_pass = flags[2] || (flags[3] != flags[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Logical ops only own N and Z; carry and overflow survive them.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= FETCH;
            ir      <= '0;
            flags   <= FLAGS_RST;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (state == FETCH && RUN)
                ir <= Instr[31:20];
            if (state == DECODE && bad)
                illegal <= 1'b1;
            if (state == EXEC && is_dp && (sbit || is_cmp)) begin
                if (alu_op[1])
                    flags[3:2] <= ALUFlags[3:2];
                else
                    flags <= ALUFlags;
            end
        end
    end

    always_comb begin
        next_state = FETCH;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUControl = 2'b00;
        ALUSrc     = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        InstrDone  = 1'b0;
        case (state)
            FETCH: next_state = RUN ? DECODE : FETCH;
            DECODE: begin
                if (bad || !cond_pass) begin
                    PCWrite   = 1'b1;
                    InstrDone = 1'b1;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (is_dp) begin
                    ALUControl = alu_op;
                    ALUSrc     = imm ? 2'b01 : 2'b00;
                end else begin
                    ALUSrc    = 2'b01;
                    ImmSrc    = is_br ? 2'b10 : 2'b01;
                    RegSrc[0] = is_br;
                end
                next_state = is_mem ? MEM : WB;
            end
            MEM: begin
                if (sbit) begin
                    next_state = WB;
                end else begin
                    MemWrite  = 1'b1;
                    RegSrc    = 2'b10;
                    PCWrite   = 1'b1;
                    InstrDone = 1'b1;
                end
            end
            WB: begin
                RegWrite  = (is_dp && !is_cmp) || is_mem;
                MemtoReg  = is_mem;
                PCSrc     = is_br;
                PCWrite   = 1'b1;
                InstrDone = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    assign State   = state;
    assign Flags   = flags;
    assign Illegal = illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction's per-cycle control trace is predicted
// from the instruction and a model NZCV register, then compared cycle by cycle.
module tb_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        RUN;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, PCSrc, RegWrite, MemWrite, MemtoReg, InstrDone, Illegal;
    logic [1:0]  ALUControl, ALUSrc, ImmSrc, RegSrc;
    logic [3:0]  Flags;
    logic [2:0]  State;

    int          vectors = 0;
    int          miscompares = 0;
    logic [21:0] exp_q[$];
    logic [3:0]  mflags;
    logic        millegal;
    logic [21:0] want;

    localparam logic [31:0] ADDS = 32'hE0910002;
    localparam logic [31:0] JUNK = 32'hFFFFFFFF;

    always #5 CLK = ~CLK;

    multicycle_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .Flags(Flags), .State(State), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    wire [21:0] actual = {State, PCWrite, PCSrc, RegWrite, MemWrite, MemtoReg,
                          ALUControl, ALUSrc, ImmSrc, RegSrc, Flags, InstrDone, Illegal};

    function automatic logic [21:0] vec(logic [2:0] st, logic pw, logic ps, logic rw, logic mw,
                                        logic mr, logic [1:0] ac, logic [1:0] asrc,
                                        logic [1:0] isrc, logic [1:0] rs, logic dn);
        return {st, pw, ps, rw, mw, mr, ac, asrc, isrc, rs, mflags, dn, millegal};
    endfunction

    function automatic logic cond_ok(logic [3:0] c, logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Pushes the expected outputs seen after each clock edge, from DECODE back to FETCH.
    task automatic predict(input logic [31:0] ins, input logic [3:0] af);
        logic [1:0] op;
        logic [3:0] cmd;
        logic [1:0] ac;
        logic       legal, isdp, ismem, isb, logical;
        op    = ins[27:26];
        cmd   = ins[24:21];
        isdp  = (op == 2'd0);
        ismem = (op == 2'd1);
        isb   = (op == 2'd2);
        legal = (op != 2'd3);
        ac    = 2'd0;
        if (isdp) begin
            case (cmd)
                4'b0100: ac = 2'd0;
                4'b0010: ac = 2'd1;
                4'b0000: ac = 2'd2;
                4'b1100: ac = 2'd3;
                4'b1010: ac = 2'd1;
                default: legal = 1'b0;
            endcase
        end
        if (!legal || !cond_ok(ins[31:28], mflags)) begin
            exp_q.push_back(vec(3'd1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1));
            if (!legal) millegal = 1'b1;
            exp_q.push_back(vec(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
            return;
        end
        exp_q.push_back(vec(3'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        if (isdp)
            exp_q.push_back(vec(3'd2, 0, 0, 0, 0, 0, ac, {1'b0, ins[25]}, 2'd0, 2'd0, 0));
        else if (ismem)
            exp_q.push_back(vec(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0, 0));
        else
            exp_q.push_back(vec(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd1, 0));
        logical = (cmd == 4'b0000) || (cmd == 4'b1100);
        if (isdp && (ins[20] || cmd == 4'b1010)) begin
            if (logical) mflags[3:2] = af[3:2];
            else         mflags = af;
        end
        if (ismem && !ins[20]) begin
            exp_q.push_back(vec(3'd3, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd2, 1));
        end else begin
            if (ismem)
                exp_q.push_back(vec(3'd3, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
            exp_q.push_back(vec(3'd4, 1, isb, (isdp && cmd != 4'b1010) || ismem, 0, ismem,
                                2'd0, 2'd0, 2'd0, 2'd0, 1));
        end
        exp_q.push_back(vec(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
    endtask

    task automatic apply_instr(input logic [31:0] ins, input logic [3:0] af);
        Instr    = ins;
        ALUFlags = af;
        RUN      = 1'b1;
        predict(ins, af);
    endtask

    task automatic test_reset();
        RST_N    = 1'b0;
        RUN      = 1'b1;
        Instr    = ADDS;
        ALUFlags = 4'b0110;
        mflags   = 4'b0000;
        millegal = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        want = vec(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
        vectors++;
        if (actual !== want) begin
            miscompares++;
            $display("[TB] FAIL reset: got %h want %h", actual, want);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_single(input string name, input logic [31:0] ins, input logic [3:0] af);
        int n = 0;
        apply_instr(ins, af);
        while (exp_q.size() > 0) begin
            @(posedge CLK);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (actual !== want) begin
                miscompares++;
                $display("[TB] FAIL %s cyc%0d: got %h want %h", name, n, actual, want);
            end
            RUN   = 1'b0;
            Instr = JUNK;
            n++;
        end
    endtask

    task automatic test_adds();
        test_single("adds", ADDS, 4'b0110);
        vectors++;
        if (Flags !== 4'b0110) begin
            miscompares++;
            $display("[TB] FAIL adds_flags: got %b want 0110", Flags);
        end
    endtask

    task automatic test_cmp_orr();
        test_single("cmp", 32'hE3510005, 4'b1000);
        vectors++;
        if (Flags !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL cmp_flags: got %b want 1000", Flags);
        end
        test_single("orrs", 32'hE3910001, 4'b0111);
        vectors++;
        if (Flags !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL orrs_flags: got %b want 0100", Flags);
        end
    endtask

    // Every condition code as a branch, under several NZCV values loaded by an ADDS.
    task automatic test_conditions();
        logic [3:0] pats [6] = '{4'b0000, 4'b0100, 4'b0010, 4'b1000, 4'b1001, 4'b0110};
        logic [31:0] ins;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 16; c++) begin
                for (int k = 0; k < 2; k++) begin
                    ins = (k == 0) ? ADDS : {c[3:0], 4'b1010, 24'h000010};
                    apply_instr(ins, pats[p]);
                    while (exp_q.size() > 0) begin
                        @(posedge CLK);
                        #1;
                        want = exp_q.pop_front();
                        vectors++;
                        if (actual !== want) begin
                            miscompares++;
                            $display("[TB] FAIL cond flags=%b cc=%h k=%0d: got %h want %h",
                                     pats[p], c, k, actual, want);
                        end
                        RUN   = 1'b0;
                        Instr = JUNK;
                    end
                end
            end
        end
    endtask

    task automatic test_run_hold();
        RUN   = 1'b0;
        Instr = ADDS;
        repeat (4) exp_q.push_back(vec(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        while (exp_q.size() > 0) begin
            @(posedge CLK);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (actual !== want) begin
                miscompares++;
                $display("[TB] FAIL run_hold: got %h want %h", actual, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        Instr    = ADDS;
        ALUFlags = 4'b0011;
        RUN      = 1'b1;
        @(posedge CLK);
        #1;
        RUN  = 1'b0;
        want = vec(3'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
        vectors++;
        if (actual !== want) begin
            miscompares++;
            $display("[TB] FAIL mid_decode: got %h want %h", actual, want);
        end
        @(posedge CLK);
        #1;
        want = vec(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
        vectors++;
        if (actual !== want) begin
            miscompares++;
            $display("[TB] FAIL mid_exec: got %h want %h", actual, want);
        end
        RST_N    = 1'b0;
        mflags   = 4'b0000;
        millegal = 1'b0;
        exp_q.delete();
        exp_q.push_back(vec(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        exp_q.push_back(vec(3'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0));
        while (exp_q.size() > 0) begin
            @(posedge CLK);
            #1;
            RST_N = 1'b1;
            want  = exp_q.pop_front();
            vectors++;
            if (actual !== want) begin
                miscompares++;
                $display("[TB] FAIL mid_reset: got %h want %h", actual, want);
            end
        end
    endtask

    task automatic test_illegal();
        test_single("illegal", 32'hEC000000, 4'b1111);
        vectors++;
        if (Illegal !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL illegal_sticky: got %b want 1", Illegal);
        end
    endtask

    // RUN held high: an illegal undefined cmd and then a plain ADD issue with no idle cycle.
    task automatic test_back_to_back();
        int n = 0;
        int na;
        apply_instr(32'hE1E10002, 4'b1111);
        na = exp_q.size();
        predict(32'hE0810002, 4'b1111);
        while (exp_q.size() > 0) begin
            @(posedge CLK);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (actual !== want) begin
                miscompares++;
                $display("[TB] FAIL back_to_back cyc%0d: got %h want %h", n, actual, want);
            end
            if (n == 0)  Instr = 32'hE0810002;
            if (n == na) begin
                RUN   = 1'b0;
                Instr = JUNK;
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_adds();
        test_single("bne", 32'h1A000003, 4'b0000);
        test_single("ldr", 32'hE5912004, 4'b0000);
        test_single("str", 32'hE5812004, 4'b0000);
        test_cmp_orr();
        test_single("subs_imm", 32'hE2510001, 4'b1001);
        test_single("ands", 32'hE0110002, 4'b0110);
        test_conditions();
        test_run_hold();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
